memory_responder: RTL and testbench

Memory-side endpoint of the word-wide MEM request/response handshake. It accepts requests on the `MEM_SEND_*` channel and serves them from an internal word-addressed RAM. Reads return data on the `MEM_RECEIVE_*` channel after a fixed, parameterised latency. It sits opposite `function_expander` and other MEM initiators, and serves as both the simulation memory model and the on-chip code/data store.

---
 rtl/memory_responder_pkg.sv | 21 ++
 rtl/ram_sp.sv | 38 +++
 rtl/memory_responder.sv | 126 ++++++++++++
 tb/tb_memory_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared constants and FSM encoding for the memory_responder block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   DATA_W / ADDR_W : 32-bit MEM data and byte-address widths
//   CNT_W           : latency counter width (covers LATENCY up to 15)
//   resp_state_t    : responder FSM states
package memory_responder_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, 2^ADDR_BITS x DATA_BITS, write-enable, registered read.
// Latency: read data appears after the enabled read edge; writes land on the enabled edge.
// Backpressure: none; rdata holds its value until the next enabled read.
//
// Ports:
//   clk   : rising-edge clock
//   en    : port enable; a cycle with en=0 leaves the array and rdata untouched
//   we    : with en, write wdata to addr; otherwise read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (not reset)
module ram_sp #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

    // rdata only updates on an enabled read, so it acts as the captured
    // read word for as long as the caller needs it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side endpoint of the MEM request/response handshake, backed by a word RAM.
// Latency: read accepted at edge N raises MEM_RECEIVE_VALID after edge N+LATENCY; writes complete at accept.
// Backpressure: one read outstanding; MEM_SEND_READY low until the response handshake, data held while MEM_RECEIVE_READY=0.
//
// Ports:
//   CLK, RST                        : clock (rising edge), async active-high reset
//   MEM_SEND_ADDR_VALID/ADDR        : request present / byte address
//   MEM_SEND_DATA_VALID/DATA        : marks request as write / write data
//   MEM_SEND_READY                  : request accepted when VALID & READY
//   MEM_RECEIVE_VALID/DATA/READY    : read response handshake
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MEM_SEND_ADDR_VALID,
    input  logic [ADDR_W-1:0] MEM_SEND_ADDR,
    input  logic              MEM_SEND_DATA_VALID,
    input  logic [DATA_W-1:0] MEM_SEND_DATA,
    output logic              MEM_SEND_READY,
    output logic              MEM_RECEIVE_VALID,
    output logic [DATA_W-1:0] MEM_RECEIVE_DATA,
    input  logic              MEM_RECEIVE_READY
);

    resp_state_t          state;
    resp_state_t          state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ready_q;
    logic                 valid_q;
    logic [DATA_W-1:0]    data_q;

    logic                 accept;
    logic                 handshake;
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] word_idx;
    logic [DATA_W-1:0]    ram_rdata;

    // Byte-offset bits and bits above the array size are don't-care:
    // addresses alias modulo 4*2^ADDR_BITS.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{MEM_SEND_ADDR[ADDR_W-1:ADDR_BITS+2], MEM_SEND_ADDR[1:0]};

    assign word_idx  = MEM_SEND_ADDR[ADDR_BITS+1:2];

    // ready_q is only ever high in IDLE, so it alone gates acceptance.
    assign accept    = ready_q && MEM_SEND_ADDR_VALID;
    assign handshake = valid_q && MEM_RECEIVE_READY;

    ram_sp #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_W)
    ) u_ram (
        .clk   (CLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (MEM_SEND_DATA),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_en    = accept;
        ram_we    = accept && MEM_SEND_DATA_VALID;

        case (state)
            ST_IDLE: begin
                if (accept && !MEM_SEND_DATA_VALID) begin
                    if (LATENCY == 1) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (handshake) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // RESP is entered one edge before VALID rises: that first RESP cycle
    // moves the RAM read word into the output register, which keeps every
    // output registered and gives exactly LATENCY edges to VALID.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == ST_IDLE);
            valid_q <= (state == ST_RESP) && !handshake;
            if (state == ST_RESP && !valid_q) begin
                data_q <= ram_rdata;
            end
        end
    end

    assign MEM_SEND_READY    = ready_q;
    assign MEM_RECEIVE_VALID = valid_q;
    assign MEM_RECEIVE_DATA  = data_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder across three parameter sets.
// Latency: instance 0 = ADDR_BITS 8 / LATENCY 1, 1 = 10 / 3, 2 = 10 / 4.
// Backpressure: exercised on instance 1 by holding MEM_RECEIVE_READY low.
module tb_memory_responder;

    logic        CLK;
    logic        RST;
    logic [2:0]  av;
    logic [2:0]  dv;
    logic [2:0]  rr;
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic [2:0]  sr;
    logic [2:0]  rv;
    logic [31:0] rd   [3];

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] sb_q [$];
    logic [31:0] model [int];
    logic [31:0] last_exp;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        memory_responder #(
            .ADDR_BITS ((g == 0) ? 8 : 10),
            .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) dut (
            .CLK                 (CLK),
            .RST                 (RST),
            .MEM_SEND_ADDR_VALID (av[g]),
            .MEM_SEND_ADDR       (addr[g]),
            .MEM_SEND_DATA_VALID (dv[g]),
            .MEM_SEND_DATA       (wdat[g]),
            .MEM_SEND_READY      (sr[g]),
            .MEM_RECEIVE_VALID   (rv[g]),
            .MEM_RECEIVE_DATA    (rd[g]),
            .MEM_RECEIVE_READY   (rr[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before 500us");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic int key_of(input int i, input logic [31:0] a);
        logic [31:0] mask;
        mask = (i == 0) ? 32'h0000_00FF : 32'h0000_03FF;
        return i * 65536 + int'((a >> 2) & mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until the accept edge; returns at edge+1.
    task automatic issue(input int i, input logic [31:0] a, input logic wr,
                         input logic [31:0] d, output int waited);
        av[i] = 1'b1;
        dv[i] = wr;
        addr[i] = a;
        wdat[i] = d;
        waited = 0;
        while (sr[i] !== 1'b1 && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        check("accept_timeout", 32'(waited >= 20), 32'd0);
        @(posedge CLK); #1;
        av[i] = 1'b0;
        dv[i] = 1'b0;
        if (wr) model[key_of(i, a)] = d;
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d);
        int w;
        issue(i, a, 1'b1, d, w);
    endtask

    task automatic read_check(input int i, input logic [31:0] a, input string tag);
        int w;
        int lat;
        logic rdy_low;
        logic [31:0] exp;
        issue(i, a, 1'b0, 32'd0, w);
        sb_q.push_back(model.exists(key_of(i, a)) ? model[key_of(i, a)] : 32'hxxxx_xxxx);
        lat = 0;
        rdy_low = 1'b1;
        while (rv[i] !== 1'b1 && lat < 40) begin
            if (sr[i] !== 1'b0) rdy_low = 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_of(i)));
        check({tag, "_ready_low"}, {31'd0, rdy_low}, 32'd1);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
        last_exp = exp;
        check({tag, "_data"}, rd[i], exp);
        if (rr[i]) begin
            @(posedge CLK); #1;
            check({tag, "_valid_drop"}, {31'd0, rv[i]}, 32'd0);
            check({tag, "_ready_back"}, {31'd0, sr[i]}, 32'd1);
        end
    endtask

    initial begin
        int w;
        logic seen;
        RST = 1'b1;
        av = '0;
        dv = '0;
        rr = 3'b111;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            wdat[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ready", {29'd0, sr}, 32'd0);
        check("rst_valid", {29'd0, rv}, 32'd0);
        check("rst_data0", rd[0], 32'd0);

        // A request held across release and the first edge is not accepted
        av[1] = 1'b1;
        addr[1] = 32'h20;
        RST = 1'b0;
        check("release_ready", {31'd0, sr[0]}, 32'd0);
        @(posedge CLK); #1;
        av[1] = 1'b0;
        check("first_edge_ready", {29'd0, sr}, 32'd7);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            if (rv[1] !== 1'b0) seen = 1'b1;
        end
        check("early_req_ignored", {31'd0, seen}, 32'd0);

        // Write then read, LATENCY 1; a write produces no response
        do_write(0, 32'h10, 32'h1234_5678);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (rv[0] !== 1'b0) seen = 1'b1;
            @(posedge CLK); #1;
        end
        check("no_write_resp", {31'd0, seen}, 32'd0);
        read_check(0, 32'h10, "l1_read");

        // LATENCY 3
        do_write(1, 32'h20, 32'hDEAD_BEEF);
        read_check(1, 32'h20, "l3_read");

        // Aliasing with ADDR_BITS 8: 0x403 maps to word 0
        do_write(0, 32'h000, 32'h0000_0000);
        do_write(0, 32'h403, 32'hA5A5_A5A5);
        read_check(0, 32'h000, "alias_read");
        read_check(0, 32'h10, "alias_untouched");

        // Backpressure on instance 1
        rr[1] = 1'b0;
        read_check(1, 32'h20, "bp_read");
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            check("bp_valid_hold", {31'd0, rv[1]}, 32'd1);
            check("bp_data_hold", rd[1], last_exp);
        end
        check("bp_ready_low", {31'd0, sr[1]}, 32'd0);
        rr[1] = 1'b1;
        @(posedge CLK); #1;
        check("bp_release_valid", {31'd0, rv[1]}, 32'd0);
        check("bp_release_ready", {31'd0, sr[1]}, 32'd1);

        // Back-to-back writes sustain one per cycle
        for (int k = 0; k < 4; k++) begin
            issue(0, 32'(k * 4), 1'b1, 32'(k + 1), w);
            check("b2b_no_stall", 32'(w), 32'd0);
        end
        check("b2b_ready", {31'd0, sr[0]}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            read_check(0, 32'(k * 4), "b2b_read");
        end

        // LATENCY 4, then reset in the middle of WAIT
        do_write(2, 32'h30, 32'hCAFE_F00D);
        read_check(2, 32'h30, "l4_read");
        issue(2, 32'h30, 1'b0, 32'd0, w);
        @(posedge CLK); #1;
        #2;
        RST = 1'b1;
        #1;
        check("midwait_rst_ready", {31'd0, sr[2]}, 32'd0);
        check("midwait_rst_valid", {31'd0, rv[2]}, 32'd0);
        check("midwait_rst_data", rd[2], 32'd0);
        check("midwait_rst_data0", rd[0], 32'd0);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        check("post_rst_ready_low", {31'd0, sr[2]}, 32'd0);
        @(posedge CLK); #1;
        check("post_rst_ready_high", {31'd0, sr[2]}, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (rv[2] !== 1'b0) seen = 1'b1;
            @(posedge CLK); #1;
        end
        check("no_stray_resp", {31'd0, seen}, 32'd0);
        check("post_rst_data", rd[2], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
